// File: rtl/sti_dac_multibank.sv
// Serial-transmit and data-arrangement controller: serialises parallel words as byte-aligned frames,
// repacks the stream into bytes and writes them checkerboard-interleaved across odd/even memory pairs.
module sti_dac_multibank #(
    parameter int DATA_W    = 16,
    parameter int MAX_BYTES = 4,
    parameter int ADDR_W    = 5,
    parameter int NUM_BANKS = 4,
    parameter int ROW_BYTES = 8,
    localparam int LEN_W    = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [DATA_W-1:0]      pi_data,
    input  logic [LEN_W-1:0]       pi_length,
    input  logic                   pi_fill,
    input  logic                   pi_msb,
    input  logic                   pi_low,
    input  logic                   pi_end,
    output logic                   busy,
    output logic                   so_data,
    output logic                   so_valid,
    output logic [7:0]             oem_dataout,
    output logic [ADDR_W-1:0]      oem_addr,
    output logic [2*NUM_BANKS-1:0] oem_wr,
    output logic                   oem_finish,
    output logic                   overflow
);

    localparam int FRAME_W = 8 * MAX_BYTES;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int TOTAL   = NUM_BANKS * (2 ** (ADDR_W + 1));
    localparam int B_W     = $clog2(TOTAL + 1);
    localparam int WR_W    = 2 * NUM_BANKS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAD   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [FRAME_W-1:0]  frame_q;
    logic                msb_q;
    logic [CNT_W-1:0]    len_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [7:0]          byte_q;
    logic                wr_pend_q;
    logic [B_W-1:0]      b_q;
    logic                busy_q;
    logic                so_data_q;
    logic                so_valid_q;
    logic [7:0]          oem_dataout_q;
    logic [ADDR_W-1:0]   oem_addr_q;
    logic [WR_W-1:0]     oem_wr_q;
    logic                finish_q;
    logic                overflow_q;

    logic [CNT_W-1:0]    len_bits_d;
    logic [FRAME_W-1:0]  data_ext_d;
    logic [FRAME_W-1:0]  frame_val_d;
    logic [FRAME_W-1:0]  frame_d;
    logic                ser_bit_d;
    logic                row_odd_d;
    logic                sel_even_d;
    logic [B_W-1:0]      wr_idx_d;
    logic [WR_W-1:0]     strb_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                room_d;

    // Frame construction from the current inputs; right-aligned value, then left-aligned for MSB-first
    always_comb begin
        len_bits_d  = (CNT_W'(pi_length) + CNT_W'(1)) << 3;
        data_ext_d  = FRAME_W'(pi_data);
        frame_val_d = '0;
        if (len_bits_d >= CNT_W'(DATA_W)) begin
            if (pi_fill) begin
                frame_val_d = data_ext_d << (len_bits_d - CNT_W'(DATA_W));
            end else begin
                frame_val_d = data_ext_d;
            end
        end else begin
            if (pi_low) begin
                frame_val_d = data_ext_d >> (CNT_W'(DATA_W) - len_bits_d);
            end else begin
                frame_val_d = data_ext_d & ~({FRAME_W{1'b1}} << len_bits_d);
            end
        end
        if (pi_msb) begin
            frame_d = frame_val_d << (CNT_W'(FRAME_W) - len_bits_d);
        end else begin
            frame_d = frame_val_d;
        end
    end

    // Byte-index to memory mapping; odd/even target swaps on every row
    always_comb begin
        ser_bit_d  = msb_q ? frame_q[FRAME_W-1] : frame_q[0];
        row_odd_d  = ((b_q / B_W'(ROW_BYTES)) & B_W'(1)) != B_W'(0);
        sel_even_d = b_q[0] ^ row_odd_d;
        wr_idx_d   = ((b_q >> (ADDR_W + 1)) << 1) | B_W'(sel_even_d);
        strb_d     = WR_W'(1) << wr_idx_d;
        addr_d     = ADDR_W'(b_q >> 1);
        room_d     = (b_q != B_W'(TOTAL));
    end

    // Control FSM, serialiser, byte assembly and memory write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            frame_q       <= '0;
            msb_q         <= 1'b0;
            len_q         <= '0;
            bit_cnt_q     <= '0;
            byte_q        <= 8'h00;
            wr_pend_q     <= 1'b0;
            b_q           <= '0;
            busy_q        <= 1'b0;
            so_data_q     <= 1'b0;
            so_valid_q    <= 1'b0;
            oem_dataout_q <= 8'h00;
            oem_addr_q    <= '0;
            oem_wr_q      <= '0;
            finish_q      <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            oem_wr_q  <= '0;
            wr_pend_q <= 1'b0;
            // A completed byte is written one cycle after its last bit, or dropped once memory is full
            if (wr_pend_q) begin
                if (room_d) begin
                    oem_wr_q      <= strb_d;
                    oem_addr_q    <= addr_d;
                    oem_dataout_q <= byte_q;
                    b_q           <= b_q + B_W'(1);
                end else begin
                    overflow_q <= 1'b1;
                end
            end
            case (state_q)
                S_IDLE: begin
                    so_valid_q <= 1'b0;
                    so_data_q  <= 1'b0;
                    if (load) begin
                        frame_q   <= frame_d;
                        msb_q     <= pi_msb;
                        len_q     <= len_bits_d;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_SHIFT;
                    end else if (pi_end) begin
                        busy_q <= 1'b1;
                        if (room_d) begin
                            state_q <= S_PAD;
                        end else begin
                            finish_q <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt_q != len_q) begin
                        so_data_q  <= ser_bit_d;
                        so_valid_q <= 1'b1;
                        byte_q     <= {byte_q[6:0], ser_bit_d};
                        frame_q    <= msb_q ? (frame_q << 1) : (frame_q >> 1);
                        bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                        wr_pend_q  <= (bit_cnt_q[2:0] == 3'd7);
                    end else begin
                        so_data_q  <= 1'b0;
                        so_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                S_PAD: begin
                    if (room_d) begin
                        oem_wr_q      <= strb_d;
                        oem_addr_q    <= addr_d;
                        oem_dataout_q <= 8'h00;
                        b_q           <= b_q + B_W'(1);
                    end else begin
                        finish_q <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign so_data     = so_data_q;
    assign so_valid    = so_valid_q;
    assign oem_dataout = oem_dataout_q;
    assign oem_addr    = oem_addr_q;
    assign oem_wr      = oem_wr_q;
    assign oem_finish  = finish_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_sti_dac_multibank.sv
// Directed self-checking bench for sti_dac_multibank with default parameters (TOTAL = 256 bytes).
module tb_sti_dac_multibank;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill;
    logic        pi_msb;
    logic        pi_low;
    logic        pi_end;
    logic        busy;
    logic        so_data;
    logic        so_valid;
    logic [7:0]  oem_dataout;
    logic [4:0]  oem_addr;
    logic [7:0]  oem_wr;
    logic        oem_finish;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic       bits_q[$];
    logic [7:0] strb_q[$];
    logic [4:0] addr_q[$];
    logic [7:0] data_q[$];
    int         cyc_q[$];

    sti_dac_multibank dut (
        .clk(clk), .reset(reset), .load(load), .pi_data(pi_data), .pi_length(pi_length),
        .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end), .busy(busy),
        .so_data(so_data), .so_valid(so_valid), .oem_dataout(oem_dataout), .oem_addr(oem_addr),
        .oem_wr(oem_wr), .oem_finish(oem_finish), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record serial bits and memory writes away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            if (so_valid) bits_q.push_back(so_data);
            if (oem_wr != 8'h00) begin
                strb_q.push_back(oem_wr);
                addr_q.push_back(oem_addr);
                data_q.push_back(oem_dataout);
                cyc_q.push_back(cyc);
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        bits_q.delete();
        strb_q.delete();
        addr_q.delete();
        data_q.delete();
        cyc_q.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) check_val("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_reset;
        load   = 1'b0;
        pi_end = 1'b0;
        reset  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] len, input logic fill,
                        input logic msb, input logic low);
        wait_idle(100);
        pi_data   = d;
        pi_length = len;
        pi_fill   = fill;
        pi_msb    = msb;
        pi_low    = low;
        load      = 1'b1;
        tick();
        load = 1'b0;
        wait_idle(100);
        tick();
    endtask

    initial begin
        logic [15:0] exp16;
        logic [7:0]  v;
        int          n;
        int          nz;

        reset = 1'b1; load = 1'b0; pi_data = 16'h0000; pi_length = 2'd0;
        pi_fill = 1'b0; pi_msb = 1'b0; pi_low = 1'b0; pi_end = 1'b0;
        tick();
        tick();
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_valid", 32'(so_valid), 32'd0);
        check_val("rst_wr", 32'(oem_wr), 32'd0);
        check_val("rst_addr", 32'(oem_addr), 32'd0);
        check_val("rst_data", 32'(oem_dataout), 32'd0);
        check_val("rst_finish", 32'(oem_finish), 32'd0);
        check_val("rst_ovf", 32'(overflow), 32'd0);

        // 1: reset in the middle of a frame
        reset = 1'b0;
        tick();
        pi_data = 16'hFFFF; pi_length = 2'd3; pi_fill = 1'b1; pi_msb = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        check_val("t1_midframe_valid", 32'(so_valid), 32'd1);
        reset = 1'b1;
        #1;
        check_val("t1_rst_valid", 32'(so_valid), 32'd0);
        check_val("t1_rst_sdata", 32'(so_data), 32'd0);
        check_val("t1_rst_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        tick(); tick();
        check_val("t1_after_busy", 32'(busy), 32'd0);

        // 2: 16-bit MSB-first frame, cycle-exact
        clear_mon();
        pi_data = 16'hA5C3; pi_length = 2'd1; pi_fill = 1'b0; pi_msb = 1'b1; pi_low = 1'b0;
        load = 1'b1;
        tick();
        load = 1'b0;
        check_val("t2_t0_busy", 32'(busy), 32'd1);
        check_val("t2_t0_valid", 32'(so_valid), 32'd0);
        exp16 = 16'hA5C3;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check_val("t2_valid", 32'(so_valid), 32'd1);
            check_val("t2_bit", 32'(so_data), 32'(exp16[16-i]));
            if (i == 9) begin
                check_val("t2_wr0", 32'(oem_wr), 32'h01);
                check_val("t2_addr0", 32'(oem_addr), 32'd0);
                check_val("t2_data0", 32'(oem_dataout), 32'hA5);
            end
        end
        tick();
        check_val("t2_end_valid", 32'(so_valid), 32'd0);
        check_val("t2_end_busy", 32'(busy), 32'd0);
        check_val("t2_wr1", 32'(oem_wr), 32'h02);
        check_val("t2_addr1", 32'(oem_addr), 32'd0);
        check_val("t2_data1", 32'(oem_dataout), 32'hC3);
        tick();

        // 3: 8-bit frame, upper byte, LSB first (byte index 2)
        clear_mon();
        send(16'h1F00, 2'd0, 1'b0, 1'b0, 1'b1);
        check_val("t3_nbits", 32'(bits_q.size()), 32'd8);
        v = 8'h00;
        for (int i = 0; i < bits_q.size(); i++) v = {v[6:0], bits_q[i]};
        check_val("t3_serial", 32'(v), 32'hF8);
        check_val("t3_nwr", 32'(strb_q.size()), 32'd1);
        check_val("t3_strb", 32'(strb_q[0]), 32'h01);
        check_val("t3_addr", 32'(addr_q[0]), 32'd1);
        check_val("t3_data", 32'(data_q[0]), 32'hF8);

        // 4: 24-bit frame, data in low bits; a load while busy is ignored (bytes 3..5)
        clear_mon();
        pi_data = 16'hBEEF; pi_length = 2'd2; pi_fill = 1'b0; pi_msb = 1'b1; pi_low = 1'b0;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        load = 1'b1;
        tick(); tick(); tick();
        load = 1'b0;
        wait_idle(100);
        for (int i = 0; i < 5; i++) tick();
        check_val("t4_nbits", 32'(bits_q.size()), 32'd24);
        check_val("t4_nwr", 32'(strb_q.size()), 32'd3);
        check_val("t4_d0", 32'(data_q[0]), 32'h00);
        check_val("t4_d1", 32'(data_q[1]), 32'hBE);
        check_val("t4_d2", 32'(data_q[2]), 32'hEF);
        check_val("t4_s0", 32'(strb_q[0]), 32'h02);
        check_val("t4_s1", 32'(strb_q[1]), 32'h01);
        check_val("t4_a1", 32'(addr_q[1]), 32'd2);

        // 5: 32-bit fill frame crosses into row 1 (bytes 6..9)
        clear_mon();
        send(16'h1234, 2'd3, 1'b1, 1'b1, 1'b0);
        check_val("t5_nwr", 32'(strb_q.size()), 32'd4);
        check_val("t5_d0", 32'(data_q[0]), 32'h12);
        check_val("t5_d1", 32'(data_q[1]), 32'h34);
        check_val("t5_s1", 32'(strb_q[1]), 32'h02);
        check_val("t5_a1", 32'(addr_q[1]), 32'd3);
        check_val("t5_s8", 32'(strb_q[2]), 32'h02);
        check_val("t5_a8", 32'(addr_q[2]), 32'd4);
        check_val("t5_s9", 32'(strb_q[3]), 32'h01);
        check_val("t5_a9", 32'(addr_q[3]), 32'd4);

        // 6a: two bytes then pi_end -> zero padding up to 256 bytes
        do_reset();
        send(16'hABCD, 2'd1, 1'b0, 1'b1, 1'b0);
        clear_mon();
        pi_end = 1'b1;
        n = 0;
        while (!oem_finish && n < 400) begin
            tick();
            n++;
        end
        pi_end = 1'b0;
        check_val("t6_finish", 32'(oem_finish), 32'd1);
        check_val("t6_npad", 32'(strb_q.size()), 32'd254);
        nz = 0;
        foreach (data_q[i]) if (data_q[i] != 8'h00) nz++;
        check_val("t6_pad_zero", 32'(nz), 32'd0);
        check_val("t6_first_strb", 32'(strb_q[0]), 32'h01);
        check_val("t6_first_addr", 32'(addr_q[0]), 32'd1);
        if (strb_q.size() > 0) begin
            check_val("t6_contig", 32'(cyc_q[cyc_q.size()-1] - cyc_q[0]), 32'd253);
            check_val("t6_last_strb", 32'(strb_q[strb_q.size()-1]), 32'h40);
            check_val("t6_last_addr", 32'(addr_q[addr_q.size()-1]), 32'd31);
            check_val("t6_finish_cyc", 32'(cyc), 32'(cyc_q[cyc_q.size()-1] + 1));
        end else begin
            check_val("t6_no_writes", 32'd0, 32'd254);
        end
        check_val("t6_busy_done", 32'(busy), 32'd1);

        // 6b: 257 bytes -> overflow, 257th write dropped, pi_end goes straight to DONE
        do_reset();
        clear_mon();
        for (int k = 0; k < 64; k++) send(16'(k * 16'h0101), 2'd3, 1'b1, 1'b1, 1'b0);
        check_val("t6b_nwr256", 32'(strb_q.size()), 32'd256);
        check_val("t6b_ovf0", 32'(overflow), 32'd0);
        check_val("t6b_fin0", 32'(oem_finish), 32'd0);
        send(16'h00AA, 2'd0, 1'b0, 1'b1, 1'b0);
        check_val("t6b_ovf1", 32'(overflow), 32'd1);
        check_val("t6b_nwr257", 32'(strb_q.size()), 32'd256);
        check_val("t6b_nbits", 32'(bits_q.size()), 32'd2056);
        pi_end = 1'b1;
        tick();
        tick();
        pi_end = 1'b0;
        check_val("t6b_finish", 32'(oem_finish), 32'd1);
        check_val("t6b_busy", 32'(busy), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
